// File: rtl/pim_dma_dot_engine.sv
// pim_dma_dot_engine
//   DMA-driven multi-lane dot-product engine. For each output it reads
//   2*vec_len bus words (activation, weight, activation, weight, ...),
//   multiplies the NUM_LANES signed elements lane-wise, and accumulates the
//   lane sums. The accumulator is post-processed (optional ReLU, then
//   saturate or wrap to DMA_BUS_WIDTH) and written back as one bus word.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   conf_info_*, conf_done   job configuration, latched on the start pulse
//   dma_read_ctrl_*          read request (index/length/size) handshake
//   dma_read_chnl_*          read data beats into the engine
//   dma_write_ctrl_*         write request handshake
//   dma_write_chnl_*         write data beat out of the engine
//   acc_done                 one-cycle job completion pulse

module pim_dot_lane #(
    parameter int ELEM_W = 8
) (
    input  logic [ELEM_W-1:0]   a,
    input  logic [ELEM_W-1:0]   b,
    output logic [2*ELEM_W-1:0] prod
);
    logic signed [2*ELEM_W-1:0] a_ext, b_ext;

    assign a_ext = {{ELEM_W{a[ELEM_W-1]}}, a};
    assign b_ext = {{ELEM_W{b[ELEM_W-1]}}, b};
    // Low 2*ELEM_W bits of the extended product are the exact signed product.
    assign prod  = a_ext * b_ext;
endmodule

module pim_dma_dot_engine #(
    parameter int         DMA_BUS_WIDTH = 32,
    parameter int         NUM_LANES     = 4,
    parameter int         ACC_WIDTH     = 48,
    parameter logic [2:0] DMA_SIZE_CODE = 3'b010
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              conf_info_vec_len,
    input  logic [31:0]              conf_info_rx_size,
    input  logic [31:0]              conf_info_wr_offset,
    input  logic [1:0]               conf_info_mode,
    input  logic                     conf_done,
    input  logic                     dma_read_ctrl_ready,
    output logic                     dma_read_ctrl_valid,
    output logic [31:0]              dma_read_ctrl_data_index,
    output logic [31:0]              dma_read_ctrl_data_length,
    output logic [2:0]               dma_read_ctrl_data_size,
    output logic                     dma_read_chnl_ready,
    input  logic                     dma_read_chnl_valid,
    input  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
    input  logic                     dma_write_ctrl_ready,
    output logic                     dma_write_ctrl_valid,
    output logic [31:0]              dma_write_ctrl_data_index,
    output logic [31:0]              dma_write_ctrl_data_length,
    output logic [2:0]               dma_write_ctrl_data_size,
    input  logic                     dma_write_chnl_ready,
    output logic                     dma_write_chnl_valid,
    output logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data,
    output logic                     acc_done
);
    localparam int ELEM_W = DMA_BUS_WIDTH / NUM_LANES;
    localparam int PROD_W = 2 * ELEM_W;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DMA_BUS_WIDTH+1){1'b0}}, {(DMA_BUS_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DMA_BUS_WIDTH+1){1'b1}}, {(DMA_BUS_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE} state_t;

    typedef struct packed {
        logic [31:0] vec_len;
        logic [31:0] rx_size;
        logic [31:0] wr_offset;
        logic [1:0]  mode;
    } conf_t;

    state_t state, state_next;
    conf_t  conf;

    logic [31:0]                      out_idx;
    logic [32:0]                      beat_cnt;
    logic [32:0]                      total_beats;
    logic                             beats_done;
    logic                             rd_beat;
    logic                             last_out;
    logic [NUM_LANES-1:0][ELEM_W-1:0] a_reg;
    logic [NUM_LANES-1:0][ELEM_W-1:0] w_lanes;
    logic [NUM_LANES-1:0][PROD_W-1:0] prods;
    logic signed [ACC_WIDTH-1:0]      lane_sum;
    logic signed [ACC_WIDTH-1:0]      psum;
    logic signed [ACC_WIDTH-1:0]      acc;
    logic signed [ACC_WIDTH-1:0]      post;
    logic                             psum_v;
    logic [DMA_BUS_WIDTH-1:0]         result;

    // 33 bits so that 2*vec_len never overflows the beat comparison.
    assign total_beats = {1'b0, conf.vec_len} << 1;
    assign beats_done  = (beat_cnt >= total_beats);
    assign rd_beat     = (state == RD_DATA) && !beats_done && dma_read_chnl_valid;
    assign last_out    = (out_idx == conf.rx_size - 32'd1);
    assign w_lanes     = dma_read_chnl_data;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pim_dot_lane #(.ELEM_W(ELEM_W)) u_lane (
            .a    (a_reg[i]),
            .b    (w_lanes[i]),
            .prod (prods[i])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum = lane_sum + {{(ACC_WIDTH-PROD_W){prods[i][PROD_W-1]}}, prods[i]};
        end
    end

    // ReLU first, then saturate or wrap to the bus width.
    always_comb begin
        post = acc;
        if (conf.mode[1] && acc[ACC_WIDTH-1]) post = '0;
        if (conf.mode[0]) begin
            if (post > SAT_MAX)      post = SAT_MAX;
            else if (post < SAT_MIN) post = SAT_MIN;
        end
        result = post[DMA_BUS_WIDTH-1:0];
    end

    always_comb begin
        state_next                 = state;
        dma_read_ctrl_valid        = 1'b0;
        dma_read_ctrl_data_index   = '0;
        dma_read_ctrl_data_length  = '0;
        dma_read_ctrl_data_size    = '0;
        dma_read_chnl_ready        = 1'b0;
        dma_write_ctrl_valid       = 1'b0;
        dma_write_ctrl_data_index  = '0;
        dma_write_ctrl_data_length = '0;
        dma_write_ctrl_data_size   = '0;
        dma_write_chnl_valid       = 1'b0;
        dma_write_chnl_data        = '0;
        acc_done                   = 1'b0;
        case (state)
            IDLE: begin
                if (conf_done) state_next = (conf_info_rx_size == 32'd0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                if (conf.vec_len == 32'd0) begin
                    state_next = WR_REQ;
                end else begin
                    dma_read_ctrl_valid       = 1'b1;
                    dma_read_ctrl_data_index  = (out_idx * conf.vec_len) << 1;
                    dma_read_ctrl_data_length = conf.vec_len << 1;
                    dma_read_ctrl_data_size   = DMA_SIZE_CODE;
                    if (dma_read_ctrl_ready) state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                dma_read_chnl_ready = !beats_done;
                // Wait for the last product to land in acc before writing.
                if (beats_done && !psum_v) state_next = WR_REQ;
            end
            WR_REQ: begin
                dma_write_ctrl_valid       = 1'b1;
                dma_write_ctrl_data_index  = conf.wr_offset + out_idx;
                dma_write_ctrl_data_length = 32'd1;
                dma_write_ctrl_data_size   = DMA_SIZE_CODE;
                if (dma_write_ctrl_ready) state_next = WR_DATA;
            end
            WR_DATA: begin
                dma_write_chnl_valid = 1'b1;
                dma_write_chnl_data  = result;
                if (dma_write_chnl_ready) state_next = last_out ? DONE : RD_REQ;
            end
            DONE: begin
                acc_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            conf     <= '0;
            out_idx  <= '0;
            beat_cnt <= '0;
            a_reg    <= '0;
            psum     <= '0;
            psum_v   <= 1'b0;
            acc      <= '0;
        end else begin
            state  <= state_next;
            psum_v <= 1'b0;
            if (psum_v) acc <= acc + psum;
            case (state)
                IDLE: begin
                    if (conf_done) begin
                        conf.vec_len   <= conf_info_vec_len;
                        conf.rx_size   <= conf_info_rx_size;
                        conf.wr_offset <= conf_info_wr_offset;
                        conf.mode      <= conf_info_mode;
                        out_idx        <= '0;
                        acc            <= '0;
                    end
                end
                RD_REQ: begin
                    beat_cnt <= '0;
                    if (conf.vec_len == 32'd0) acc <= '0;
                end
                RD_DATA: begin
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + 33'd1;
                        if (!beat_cnt[0]) begin
                            a_reg <= w_lanes;
                        end else begin
                            psum   <= lane_sum;
                            psum_v <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (dma_write_chnl_ready) begin
                        out_idx <= out_idx + 32'd1;
                        acc     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pim_dma_dot_engine.sv
// tb_pim_dma_dot_engine
//   Directed bench for pim_dma_dot_engine: a 32-bit/4-lane instance driven by
//   a cycle-level DMA responder task, plus a 16-bit/2-lane instance for the
//   narrow-bus wrap/saturate vectors.

module tb_pim_dma_dot_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic [31:0] conf_info_vec_len = '0, conf_info_rx_size = '0, conf_info_wr_offset = '0;
    logic [1:0]  conf_info_mode = '0;
    logic        conf_done = 1'b0;
    logic        rd_ctrl_ready = 1'b0, rd_ctrl_valid;
    logic [31:0] rd_ctrl_index, rd_ctrl_length;
    logic [2:0]  rd_ctrl_size;
    logic        rd_chnl_ready, rd_chnl_valid = 1'b0;
    logic [31:0] rd_chnl_data = '0;
    logic        wr_ctrl_ready = 1'b0, wr_ctrl_valid;
    logic [31:0] wr_ctrl_index, wr_ctrl_length;
    logic [2:0]  wr_ctrl_size;
    logic        wr_chnl_ready = 1'b0, wr_chnl_valid;
    logic [31:0] wr_chnl_data;
    logic        acc_done;

    // 16-bit instance
    logic [31:0] h_vec_len = '0, h_rx_size = '0, h_wr_offset = '0;
    logic [1:0]  h_mode = '0;
    logic        h_conf_done = 1'b0;
    logic        h_rd_ctrl_ready = 1'b0, h_rd_ctrl_valid;
    logic [31:0] h_rd_ctrl_index, h_rd_ctrl_length;
    logic [2:0]  h_rd_ctrl_size;
    logic        h_rd_chnl_ready, h_rd_chnl_valid = 1'b0;
    logic [15:0] h_rd_chnl_data = '0;
    logic        h_wr_ctrl_ready = 1'b0, h_wr_ctrl_valid;
    logic [31:0] h_wr_ctrl_index, h_wr_ctrl_length;
    logic [2:0]  h_wr_ctrl_size;
    logic        h_wr_chnl_ready = 1'b0, h_wr_chnl_valid;
    logic [15:0] h_wr_chnl_data;
    logic        h_acc_done;

    pim_dma_dot_engine u_dut (
        .clk(clk), .rst(rst),
        .conf_info_vec_len(conf_info_vec_len), .conf_info_rx_size(conf_info_rx_size),
        .conf_info_wr_offset(conf_info_wr_offset), .conf_info_mode(conf_info_mode),
        .conf_done(conf_done),
        .dma_read_ctrl_ready(rd_ctrl_ready), .dma_read_ctrl_valid(rd_ctrl_valid),
        .dma_read_ctrl_data_index(rd_ctrl_index), .dma_read_ctrl_data_length(rd_ctrl_length),
        .dma_read_ctrl_data_size(rd_ctrl_size),
        .dma_read_chnl_ready(rd_chnl_ready), .dma_read_chnl_valid(rd_chnl_valid),
        .dma_read_chnl_data(rd_chnl_data),
        .dma_write_ctrl_ready(wr_ctrl_ready), .dma_write_ctrl_valid(wr_ctrl_valid),
        .dma_write_ctrl_data_index(wr_ctrl_index), .dma_write_ctrl_data_length(wr_ctrl_length),
        .dma_write_ctrl_data_size(wr_ctrl_size),
        .dma_write_chnl_ready(wr_chnl_ready), .dma_write_chnl_valid(wr_chnl_valid),
        .dma_write_chnl_data(wr_chnl_data),
        .acc_done(acc_done)
    );

    pim_dma_dot_engine #(.DMA_BUS_WIDTH(16), .NUM_LANES(2), .ACC_WIDTH(48)) u_dut16 (
        .clk(clk), .rst(rst),
        .conf_info_vec_len(h_vec_len), .conf_info_rx_size(h_rx_size),
        .conf_info_wr_offset(h_wr_offset), .conf_info_mode(h_mode),
        .conf_done(h_conf_done),
        .dma_read_ctrl_ready(h_rd_ctrl_ready), .dma_read_ctrl_valid(h_rd_ctrl_valid),
        .dma_read_ctrl_data_index(h_rd_ctrl_index), .dma_read_ctrl_data_length(h_rd_ctrl_length),
        .dma_read_ctrl_data_size(h_rd_ctrl_size),
        .dma_read_chnl_ready(h_rd_chnl_ready), .dma_read_chnl_valid(h_rd_chnl_valid),
        .dma_read_chnl_data(h_rd_chnl_data),
        .dma_write_ctrl_ready(h_wr_ctrl_ready), .dma_write_ctrl_valid(h_wr_ctrl_valid),
        .dma_write_ctrl_data_index(h_wr_ctrl_index), .dma_write_ctrl_data_length(h_wr_ctrl_length),
        .dma_write_ctrl_data_size(h_wr_ctrl_size),
        .dma_write_chnl_ready(h_wr_chnl_ready), .dma_write_chnl_valid(h_wr_chnl_valid),
        .dma_write_chnl_data(h_wr_chnl_data),
        .acc_done(h_acc_done)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_w [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valids"}, {59'd0, rd_ctrl_valid, rd_chnl_ready, wr_ctrl_valid, wr_chnl_valid, acc_done}, 64'd0);
        chk({tag, "_fields"}, {63'd0, |{rd_ctrl_index, rd_ctrl_length, wr_ctrl_index, wr_ctrl_length, wr_chnl_data}}, 64'd0);
    endtask

    // Reference dot product over 8-bit signed lanes, then ReLU / saturate / wrap.
    function automatic logic [31:0] model(input int base, input int vl, input logic [1:0] md);
        longint s = 0;
        longint smax = 64'sd2147483647;
        longint smin = -64'sd2147483648;
        logic [31:0] a, w;
        logic signed [7:0] ae, we;
        for (int k = 0; k < vl; k++) begin
            a = mem[(base + 2*k) & 63];
            w = mem[(base + 2*k + 1) & 63];
            for (int l = 0; l < 4; l++) begin
                ae = a[8*l +: 8];
                we = w[8*l +: 8];
                s += longint'(ae) * longint'(we);
            end
        end
        if (md[1] && s < 0) s = 0;
        if (md[0]) begin
            if (s > smax)      s = smax;
            else if (s < smin) s = smin;
        end
        return s[31:0];
    endfunction

    // Runs one job on the 32-bit instance, acting as the DMA target. Checks
    // request fields at each handshake, hold-stability while stalled, write
    // data against exp_w, transaction counts, and the acc_done pulse.
    task automatic run_job(input string tag, input logic [31:0] vl, input logic [31:0] rs,
                           input logic [31:0] off, input logic [1:0] md, input bit stall,
                           input bit poke, input int lat);
        int cyc = 0, done_cyc = -1, rd_n = 0, wr_n = 0, wr_d = 0, beat = 0, rd_base = 0;
        bit p_rcv = 0, p_rhs = 0, p_wcv = 0, p_whs = 0, p_wchv = 0, p_wdhs = 0, p_chs = 0;
        logic [31:0] p_ridx = '0, p_widx = '0, p_wdata = '0;
        conf_info_vec_len = vl; conf_info_rx_size = rs; conf_info_wr_offset = off; conf_info_mode = md;
        rd_chnl_valid = 1'b0;
        conf_done = 1'b1;
        @(posedge clk); #1;
        conf_done = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            if (p_rcv && !p_rhs) chk({tag, "_rd_ctrl_hold"}, {31'd0, rd_ctrl_valid, rd_ctrl_index}, {31'd0, 1'b1, p_ridx});
            if (p_wcv && !p_whs) chk({tag, "_wr_ctrl_hold"}, {31'd0, wr_ctrl_valid, wr_ctrl_index}, {31'd0, 1'b1, p_widx});
            if (p_wchv && !p_wdhs) chk({tag, "_wr_data_hold"}, {31'd0, wr_chnl_valid, wr_chnl_data}, {31'd0, 1'b1, p_wdata});
            chk({tag, "_no_overlap"}, {63'd0, (rd_ctrl_valid | rd_chnl_ready) & (wr_ctrl_valid | wr_chnl_valid)}, 64'd0);
            if (acc_done) done_cyc = cyc;
            if (poke && cyc == 4) begin
                conf_done = 1'b1; conf_info_vec_len = 7; conf_info_rx_size = 9; conf_info_wr_offset = 32'h55;
            end else begin
                conf_done = 1'b0;
            end
            rd_ctrl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ctrl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_chnl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!(rd_chnl_valid && !p_chs)) rd_chnl_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_ctrl_valid && rd_ctrl_ready) begin
                chk({tag, "_rd_req"}, {rd_ctrl_index, rd_ctrl_length},
                    {32'(rd_n) * vl * 32'd2, vl * 32'd2});
                chk({tag, "_rd_size"}, {61'd0, rd_ctrl_size}, 64'd2);
                rd_base = rd_n * 2 * int'(vl);
                beat = 0;
                rd_n++;
            end
            rd_chnl_data = mem[(rd_base + beat) & 63];
            p_chs = rd_chnl_ready && rd_chnl_valid;
            if (p_chs) beat++;
            if (wr_ctrl_valid && wr_ctrl_ready) begin
                chk({tag, "_wr_req"}, {wr_ctrl_index, wr_ctrl_length}, {off + 32'(wr_n), 32'd1});
                chk({tag, "_wr_size"}, {61'd0, wr_ctrl_size}, 64'd2);
                wr_n++;
            end
            if (wr_chnl_valid && wr_chnl_ready) begin
                chk({tag, "_wr_data"}, {32'd0, wr_chnl_data}, {32'd0, exp_w[wr_d & 7]});
                wr_d++;
            end
            p_rcv = rd_ctrl_valid; p_rhs = rd_ctrl_valid && rd_ctrl_ready; p_ridx = rd_ctrl_index;
            p_wcv = wr_ctrl_valid; p_whs = wr_ctrl_valid && wr_ctrl_ready; p_widx = wr_ctrl_index;
            p_wchv = wr_chnl_valid; p_wdhs = wr_chnl_valid && wr_chnl_ready; p_wdata = wr_chnl_data;
            @(posedge clk); #1;
            cyc++;
        end
        conf_done = 1'b0;
        rd_chnl_valid = 1'b0;
        chk({tag, "_done_seen"}, {63'd0, done_cyc >= 0}, 64'd1);
        chk({tag, "_rd_count"}, 64'(rd_n), (vl == 0) ? 64'd0 : 64'(rs));
        chk({tag, "_wr_count"}, 64'(wr_d), 64'(rs));
        if (rs == 0) chk({tag, "_done_fast"}, {63'd0, done_cyc <= 2}, 64'd1);
        if (lat >= 0) chk({tag, "_latency"}, 64'(done_cyc), 64'(lat));
        chk({tag, "_done_pulse"}, {63'd0, acc_done}, 64'd0);
    endtask

    task automatic run16(input string tag, input logic [1:0] md, input logic [15:0] exp);
        int cyc = 0, done_cyc = -1;
        bit got_w = 0;
        h_vec_len = 2; h_rx_size = 1; h_wr_offset = 3; h_mode = md;
        h_rd_ctrl_ready = 1'b1; h_rd_chnl_valid = 1'b1; h_rd_chnl_data = 16'h7F7F;
        h_wr_ctrl_ready = 1'b1; h_wr_chnl_ready = 1'b1;
        h_conf_done = 1'b1;
        @(posedge clk); #1;
        h_conf_done = 1'b0;
        while (done_cyc < 0 && cyc < 100) begin
            if (h_rd_ctrl_valid) chk({tag, "_rd_req"}, {h_rd_ctrl_index, h_rd_ctrl_length}, {32'd0, 32'd4});
            if (h_wr_ctrl_valid) chk({tag, "_wr_req"}, {h_wr_ctrl_index, h_wr_ctrl_length}, {32'd3, 32'd1});
            if (h_wr_chnl_valid) begin
                chk({tag, "_data"}, {48'd0, h_wr_chnl_data}, {48'd0, exp});
                got_w = 1;
            end
            if (h_acc_done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_wrote"}, {63'd0, got_w}, 64'd1);
        chk({tag, "_latency"}, 64'(done_cyc), 64'd9);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) exp_w[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle_after_reset");

        // Basic dot product: lanes 4,3,2,1 times 1 -> 10.
        mem[0] = 32'h01020304; mem[1] = 32'h01010101; exp_w[0] = 32'h0000000A;
        run_job("basic", 1, 1, 0, 2'b00, 0, 0, 7);

        // All -1 activations: wrap gives -4, ReLU clamps to 0.
        mem[0] = 32'hFFFFFFFF; mem[1] = 32'h01010101; exp_w[0] = 32'hFFFFFFFC;
        run_job("neg_wrap", 1, 1, 0, 2'b00, 0, 0, 7);
        exp_w[0] = 32'h00000000;
        run_job("neg_relu", 1, 1, 0, 2'b10, 0, 0, 7);

        // Three outputs with random stalls and a conf_done poke while busy.
        for (int i = 0; i < 12; i++) mem[i] = $urandom;
        for (int i = 0; i < 3; i++) exp_w[i] = model(i * 4, 2, 2'b00);
        run_job("stall_rx3", 2, 3, 32'h10, 2'b00, 1, 1, -1);
        for (int i = 0; i < 3; i++) exp_w[i] = model(i * 4, 2, 2'b11);
        run_job("stall_rx3_relu_sat", 2, 3, 32'h10, 2'b11, 1, 0, -1);

        // Corner cases.
        run_job("rx0", 1, 0, 0, 2'b00, 0, 0, -1);
        exp_w[0] = 32'd0; exp_w[1] = 32'd0;
        run_job("vl0", 0, 2, 5, 2'b00, 0, 0, -1);

        // Reset in the middle of a read stream.
        conf_info_vec_len = 4; conf_info_rx_size = 1; conf_info_wr_offset = 0; conf_info_mode = 0;
        rd_ctrl_ready = 1'b1; rd_chnl_valid = 1'b1; rd_chnl_data = 32'h01010101;
        conf_done = 1'b1;
        @(posedge clk); #1;
        conf_done = 1'b0;
        k = 0;
        while (!rd_chnl_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_rd_data", {63'd0, rd_chnl_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("mid_reset");
        rst = 1'b1; rd_chnl_valid = 1'b0; rd_ctrl_ready = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_reset");
        mem[0] = 32'h01020304; mem[1] = 32'h01010101; exp_w[0] = 32'h0000000A;
        run_job("after_reset", 1, 1, 0, 2'b00, 0, 0, 7);

        // Narrow bus: 2 lanes of 127*127, two pairs -> 64516.
        run16("w16_wrap", 2'b00, 16'hFC04);
        run16("w16_sat", 2'b01, 16'h7FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
